// File: rtl/wait_state_memory.sv
// wait_state_memory: single-port word store with CS/READY handshake,
// programmable wait states, byte-enable writes and an out-of-range flag.
module wait_state_memory #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 7,
    parameter int    DEPTH     = 128,
    parameter int    WAIT      = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CS,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] BE,
    output logic [DATA_W-1:0]   RDATA,
    output logic                READY,
    output logic                BUSY,
    output logic                ERR
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nx;
    logic                accept;
    logic                done;
    logic                in_range;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;

    logic [DATA_W-1:0]   mem [DEPTH];

    // One extra bit so DEPTH == 2**ADDR_W compares correctly
    assign in_range = {1'b0, lat_addr} < (ADDR_W + 1)'(DEPTH);
    assign done     = (state == S_DONE);
    assign BUSY     = (state != S_IDLE) || READY;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (CS) begin
                    accept   = 1'b1;
                    cnt_nx   = 4'(WAIT);
                    state_nx = (WAIT > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            lat_we    <= WE;
            lat_addr  <= ADDR;
            lat_wdata <= WDATA;
            lat_be    <= BE;
        end
    end

    // State is cleared asynchronously, so an aborted access never writes
    always_ff @(posedge CLK) begin
        if (done && lat_we && in_range) begin
            for (int k = 0; k < BE_W; k++) begin
                if (lat_be[k]) begin
                    mem[lat_addr][8*k +: 8] <= lat_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            READY <= 1'b0;
            ERR   <= 1'b0;
            RDATA <= '0;
        end else begin
            READY <= done;
            ERR   <= done && !in_range;
            if (done && !lat_we) begin
                RDATA <= in_range ? mem[lat_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed self-checking bench for wait_state_memory: one WAIT=2/DEPTH=100
// instance and one WAIT=0/DEPTH=128 instance on a shared clock and reset.
module tb_wait_state_memory;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic        cs_a;
    logic        we_a;
    logic [6:0]  addr_a;
    logic [31:0] wdata_a;
    logic [3:0]  be_a;
    logic [31:0] rdata_a;
    logic        ready_a;
    logic        busy_a;
    logic        err_a;

    logic        cs_b;
    logic        we_b;
    logic [6:0]  addr_b;
    logic [31:0] wdata_b;
    logic [3:0]  be_b;
    logic [31:0] rdata_b;
    logic        ready_b;
    logic        busy_b;
    logic        err_b;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] model [100];

    localparam logic [31:0] V0 = 32'h0BAD_F00D;
    localparam logic [31:0] V1 = 32'h1357_9BDF;

    always #5 CLK = ~CLK;

    wait_state_memory #(
        .DATA_W(32), .ADDR_W(7), .DEPTH(100), .WAIT(2), .INIT_FILE("")
    ) u_a (
        .CLK(CLK), .RST(RST), .CS(cs_a), .WE(we_a), .ADDR(addr_a),
        .WDATA(wdata_a), .BE(be_a), .RDATA(rdata_a), .READY(ready_a),
        .BUSY(busy_a), .ERR(err_a)
    );

    wait_state_memory #(
        .DATA_W(32), .ADDR_W(7), .DEPTH(128), .WAIT(0), .INIT_FILE("")
    ) u_b (
        .CLK(CLK), .RST(RST), .CS(cs_b), .WE(we_b), .ADDR(addr_b),
        .WDATA(wdata_b), .BE(be_b), .RDATA(rdata_b), .READY(ready_b),
        .BUSY(busy_b), .ERR(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the READY cycle,
    // or one cycle later when tail is set.
    task automatic acc_a(input logic w, input logic [6:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic tail,
                         output logic [31:0] rd, output logic er,
                         output int lat, output logic bz);
        cs_a    = 1'b1;
        we_a    = w;
        addr_a  = a;
        wdata_a = d;
        be_a    = b;
        @(posedge CLK);
        #1;
        cs_a    = 1'b0;
        we_a    = ~w;
        addr_a  = ~a;
        wdata_a = ~d;
        be_a    = ~b;
        lat = 0;
        bz  = 1'b1;
        while (!ready_a && lat < 20) begin
            bz &= busy_a;
            @(posedge CLK);
            #1;
            lat++;
        end
        bz &= busy_a;
        rd = rdata_a;
        er = err_a;
        if (tail) begin
            @(posedge CLK);
            #1;
            bz &= !busy_a && !ready_a;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        bz;
        int          lat;
        int          nrdy;
        int          j;

        cs_a = 0; we_a = 0; addr_a = '0; wdata_a = '0; be_a = '0;
        cs_b = 0; we_b = 0; addr_b = '0; wdata_b = '0; be_b = '0;

        #1 RST = 1'b1;
        #2;
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        nrdy = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            nrdy += int'(ready_a) + int'(ready_b) + int'(busy_a);
        end
        check("idle_no_ready", 32'(nrdy), 32'd0);

        for (int i = 0; i < 100; i++) begin
            logic [7:0] ib;
            logic [6:0] ia;
            ib = 8'(i);
            ia = 7'(i);
            model[ia] = {ib, ~ib, 8'h5A, ib ^ 8'hC3};
            acc_a(1'b1, ia, model[ia], 4'hF, 1'b0, rd, er, lat, bz);
        end

        acc_a(1'b1, 7'd5, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, er, lat, bz);
        model[5] = 32'hDEAD_BEEF;
        check("wr5_lat", 32'(lat), 32'd3);
        check("wr5_busy", 32'(bz), 32'd1);
        check("wr5_err", 32'(er), 32'd0);
        acc_a(1'b0, 7'd5, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("rd5_data", rd, 32'hDEAD_BEEF);
        check("rd5_lat", 32'(lat), 32'd3);
        check("rd5_busy", 32'(bz), 32'd1);

        acc_a(1'b1, 7'd9, 32'h1122_3344, 4'hF, 1'b1, rd, er, lat, bz);
        check("rdata_hold", rdata_a, 32'hDEAD_BEEF);
        acc_a(1'b1, 7'd9, 32'hAABB_CCDD, 4'b0101, 1'b1, rd, er, lat, bz);
        acc_a(1'b1, 7'd9, 32'hFFFF_FFFF, 4'b0000, 1'b1, rd, er, lat, bz);
        check("be0_lat", 32'(lat), 32'd3);
        acc_a(1'b0, 7'd9, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("be_merge", rd, 32'h11BB_33DD);
        model[9] = 32'h11BB_33DD;
        acc_a(1'b1, 7'd7, 32'h1234_5678, 4'hF, 1'b1, rd, er, lat, bz);
        model[7] = 32'h1234_5678;

        acc_a(1'b1, 7'd120, 32'h1, 4'hF, 1'b1, rd, er, lat, bz);
        check("oor_wr_err", 32'(er), 32'd1);
        check("oor_wr_lat", 32'(lat), 32'd3);
        acc_a(1'b0, 7'd120, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("oor_rd_err", 32'(er), 32'd1);
        check("oor_rd_data", rd, 32'd0);
        acc_a(1'b0, 7'd99, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("edge99_err", 32'(er), 32'd0);
        check("edge99_data", rd, model[99]);
        acc_a(1'b1, 7'd100, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("edge100_wr_err", 32'(er), 32'd1);
        acc_a(1'b0, 7'd100, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("edge100_err", 32'(er), 32'd1);
        check("edge100_data", rd, 32'd0);

        cs_a = 1'b1; we_a = 1'b1; addr_a = 7'd7;
        wdata_a = 32'hCAFE_0000; be_a = 4'hF;
        @(posedge CLK);
        #1 cs_a = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        #1 RST = 1'b0;
        nrdy = 0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            nrdy += int'(ready_a);
        end
        check("abort_no_ready", 32'(nrdy), 32'd0);
        acc_a(1'b0, 7'd7, 32'h0, 4'hF, 1'b1, rd, er, lat, bz);
        check("abort_data", rd, 32'h1234_5678);

        acc_a(1'b0, 7'd5, 32'h0, 4'hF, 1'b0, rd, er, lat, bz);
        check("pre_rst_rdata", rd, 32'hDEAD_BEEF);
        #2 RST = 1'b1;
        #1;
        check("async_ready", 32'(ready_a), 32'd0);
        check("async_busy", 32'(busy_a), 32'd0);
        check("async_err", 32'(err_a), 32'd0);
        check("async_rdata", rdata_a, 32'd0);
        #1 RST = 1'b0;
        nrdy = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            nrdy += int'(ready_a);
        end
        check("post_rst_idle", 32'(nrdy), 32'd0);

        for (int i = 0; i < 100; i++) begin
            logic [6:0] ia;
            ia = 7'(i);
            acc_a(1'b0, ia, 32'h0, 4'hF, 1'b0, rd, er, lat, bz);
            check($sformatf("mem[%0d]", i), rd, model[ia]);
        end
        @(posedge CLK);
        #1;

        cs_b = 1'b1; we_b = 1'b1; addr_b = 7'd3;
        wdata_b = V0; be_b = 4'hF;
        j = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CLK);
            #1;
            check("b_ready", 32'(ready_b), 32'((c % 2) == 0));
            check("b_busy", 32'(busy_b), 32'd1);
            if (ready_b) begin
                check("b_err", 32'(err_b), 32'd0);
                if (j % 2 == 1) begin
                    check("b_rdata", rdata_b, (j >= 2) ? V1 : V0);
                end
                j++;
                we_b    = (j % 2 == 0);
                wdata_b = (j >= 2) ? V1 : V0;
            end
        end
        cs_b = 1'b0;
        check("b_count", 32'(j), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
